// File: rtl/dkong_hs_ram_arbiter.sv
// Arbitrates the main-CPU work RAM port between the Z80 and the hiscore engine.
// Hiscore accesses pause the CPU, wait a settle delay, then take the port for one access.
module dkong_hs_ram_arbiter #(
    parameter logic [15:0] RAM_BASE = 16'h6000,
    parameter int unsigned RAM_AW   = 12,
    parameter int unsigned SETTLE   = 2,
    parameter int unsigned HOLD     = 255
) (
    input  logic              I_CLK_24576M,
    input  logic              I_RESETn,
    input  logic              I_HS_REQ,
    input  logic              I_HS_WE,
    input  logic [15:0]       I_HS_ADDR,
    input  logic [7:0]        I_HS_WDATA,
    output logic [7:0]        O_HS_RDATA,
    output logic              O_HS_ACK,
    output logic              O_PAUSE_REQ,
    input  logic              I_CPU_PAUSED,
    input  logic [RAM_AW-1:0] I_CPU_ADDR,
    input  logic              I_CPU_WE,
    input  logic [7:0]        I_CPU_WDATA,
    output logic [RAM_AW-1:0] O_RAM_ADDR,
    output logic              O_RAM_WE,
    output logic [7:0]        O_RAM_WDATA,
    input  logic [7:0]        I_RAM_RDATA,
    output logic              O_BUSY
);

    typedef enum logic [2:0] {
        StIdle,
        StPauseWait,
        StSettle,
        StAccess,
        StRead,
        StAck,
        StHold
    } state_e;

    localparam logic [16:0] WinSize    = 17'd1 << RAM_AW;
    localparam logic [3:0]  SettleLoad = 4'(SETTLE - 1);
    localparam logic [7:0]  HoldLast   = 8'(HOLD - 1);

    state_e      state_q, state_d;
    logic [3:0]  settle_q, settle_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        pause_q, pause_d;
    logic [16:0] hs_off;
    logic        in_win;
    logic        hs_own;

    // Below-base addresses wrap to a large 17-bit value and fall outside the window.
    assign hs_off = {1'b0, I_HS_ADDR} - {1'b0, RAM_BASE};
    assign in_win = hs_off < WinSize;

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        hold_d   = hold_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            StIdle: begin
                if (I_HS_REQ) begin
                    if (in_win) begin
                        state_d = StPauseWait;
                    end else begin
                        state_d = StAck;
                        rdata_d = 8'hFF;
                    end
                end
            end
            StPauseWait: begin
                if (I_CPU_PAUSED) begin
                    settle_d = SettleLoad;
                    state_d  = (SETTLE <= 1) ? StAccess : StSettle;
                end
            end
            StSettle: begin
                if (!I_CPU_PAUSED) begin
                    state_d = StPauseWait;
                end else if (settle_q <= 4'd1) begin
                    state_d = StAccess;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            StAccess: state_d = I_HS_WE ? StAck : StRead;
            StRead: begin
                rdata_d = I_RAM_RDATA;
                state_d = StAck;
            end
            StAck: begin
                hold_d  = '0;
                state_d = pause_q ? StHold : StIdle;
            end
            StHold: begin
                if (I_HS_REQ && in_win) begin
                    state_d = I_CPU_PAUSED ? StAccess : StPauseWait;
                end else if (I_HS_REQ) begin
                    state_d = StAck;
                    rdata_d = 8'hFF;
                end else if (hold_q >= HoldLast) begin
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        // An ACK keeps the pause only if it was already held (in-window or burst path).
        pause_d = (state_d != StIdle) && ((state_d != StAck) || pause_q);
    end

    always_ff @(posedge I_CLK_24576M) begin
        if (!I_RESETn) begin
            state_q  <= StIdle;
            settle_q <= '0;
            hold_q   <= '0;
            rdata_q  <= 8'h00;
            pause_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            hold_q   <= hold_d;
            rdata_q  <= rdata_d;
            pause_q  <= pause_d;
        end
    end

    assign hs_own      = (state_q == StAccess) || (state_q == StRead);
    assign O_RAM_ADDR  = hs_own ? hs_off[RAM_AW-1:0] : I_CPU_ADDR;
    assign O_RAM_WE    = hs_own ? ((state_q == StAccess) && I_HS_WE) : I_CPU_WE;
    assign O_RAM_WDATA = hs_own ? I_HS_WDATA : I_CPU_WDATA;

    assign O_HS_RDATA  = rdata_q;
    assign O_HS_ACK    = (state_q == StAck);
    assign O_PAUSE_REQ = pause_q;
    assign O_BUSY      = (state_q != StIdle);

endmodule

// File: tb/tb_dkong_hs_ram_arbiter.sv
// Directed bench for dkong_hs_ram_arbiter with a registered RAM model on the shared port.
module tb_dkong_hs_ram_arbiter;

    localparam int unsigned Hold = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        hs_req = 1'b0;
    logic        hs_we = 1'b0;
    logic [15:0] hs_addr = 16'h0000;
    logic [7:0]  hs_wdata = 8'h00;
    logic [7:0]  hs_rdata;
    logic        ack;
    logic        pause;
    logic        paused = 1'b0;
    logic [11:0] cpu_addr = 12'h000;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_wdata = 8'h00;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        busy;

    logic [7:0]  mem [0:4095];

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    dkong_hs_ram_arbiter #(
        .RAM_BASE(16'h6000),
        .RAM_AW  (12),
        .SETTLE  (2),
        .HOLD    (Hold)
    ) dut (
        .I_CLK_24576M(clk),
        .I_RESETn    (rstn),
        .I_HS_REQ    (hs_req),
        .I_HS_WE     (hs_we),
        .I_HS_ADDR   (hs_addr),
        .I_HS_WDATA  (hs_wdata),
        .O_HS_RDATA  (hs_rdata),
        .O_HS_ACK    (ack),
        .O_PAUSE_REQ (pause),
        .I_CPU_PAUSED(paused),
        .I_CPU_ADDR  (cpu_addr),
        .I_CPU_WE    (cpu_we),
        .I_CPU_WDATA (cpu_wdata),
        .O_RAM_ADDR  (ram_addr),
        .O_RAM_WE    (ram_we),
        .O_RAM_WDATA (ram_wdata),
        .I_RAM_RDATA (ram_rdata),
        .O_BUSY      (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        for (int k = 0; k < 100; k++) begin
            if (!busy) break;
            tick();
        end
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [7:0] d);
        cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (4) tick();
        total++; if (ack !== 1'b0) $display("FAIL reset_ack got %b want 0", ack); else passed++;
        total++; if (pause !== 1'b0) $display("FAIL reset_pause got %b want 0", pause); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (hs_rdata !== 8'h00) $display("FAIL reset_rdata got %h want 00", hs_rdata);
        else passed++;
        rstn = 1'b1;
        cpu_addr = 12'h123; cpu_wdata = 8'h5A; cpu_we = 1'b1;
        #1;
        total++; if (ram_we !== 1'b1) $display("FAIL cold_we got %b want 1", ram_we); else passed++;
        total++; if (ram_addr !== 12'h123) $display("FAIL cold_addr got %h want 123", ram_addr);
        else passed++;
        total++; if (ram_wdata !== 8'h5A) $display("FAIL cold_wdata got %h want 5a", ram_wdata);
        else passed++;
        tick();
        cpu_we = 1'b0;
        #1;
        total++; if (ram_we !== 1'b0) $display("FAIL cold_we_low got %b want 0", ram_we); else passed++;
        total++; if (mem[12'h123] !== 8'h5A) $display("FAIL cold_mem got %h want 5a", mem[12'h123]);
        else passed++;
        total++; if (pause !== 1'b0 || busy !== 1'b0)
            $display("FAIL cold_idle got pause=%b busy=%b want 0 0", pause, busy);
        else passed++;
        for (int i = 0; i < 8; i++) cpu_write(12'(i), 8'h30 + 8'(i));
        cpu_write(12'h030, 8'h00);
        cpu_write(12'h200, 8'h00);
    endtask

    task automatic test_single_write;
        paused = 1'b1; hs_req = 1'b1; hs_we = 1'b1; hs_addr = 16'h6010; hs_wdata = 8'hA5;
        for (int c = 1; c <= 6; c++) begin
            cpu_we = (c == 4); cpu_addr = 12'h200; cpu_wdata = 8'h77;
            if (c == 6) hs_req = 1'b0;
            #1;
            total++; if (ack !== (c == 5)) $display("FAIL wr_ack c=%0d got %b want %b", c, ack, c == 5);
            else passed++;
            total++; if (ram_we !== (c == 4))
                $display("FAIL wr_ram_we c=%0d got %b want %b", c, ram_we, c == 4);
            else passed++;
            if (c == 4) begin
                total++; if (ram_addr !== 12'h010) $display("FAIL wr_addr got %h want 010", ram_addr);
                else passed++;
                total++; if (ram_wdata !== 8'hA5) $display("FAIL wr_wdata got %h want a5", ram_wdata);
                else passed++;
            end
            tick();
        end
        cpu_we = 1'b0;
        total++; if (mem[12'h010] !== 8'hA5) $display("FAIL wr_mem got %h want a5", mem[12'h010]);
        else passed++;
        total++; if (mem[12'h200] !== 8'h00) $display("FAIL wr_cpu_masked got %h want 00", mem[12'h200]);
        else passed++;
    endtask

    task automatic test_late_pause_read;
        paused = 1'b0;
        wait_idle();
        total++; if (busy !== 1'b0 || pause !== 1'b0)
            $display("FAIL rd_pre_idle got busy=%b pause=%b want 0 0", busy, pause);
        else passed++;
        hs_req = 1'b1; hs_we = 1'b0; hs_addr = 16'h6010;
        for (int c = 1; c <= 13; c++) begin
            paused = (c >= 8);
            if (c == 13) hs_req = 1'b0;
            #1;
            total++; if (ack !== (c == 12)) $display("FAIL rd_ack c=%0d got %b want %b", c, ack, c == 12);
            else passed++;
            total++; if (pause !== (c >= 2))
                $display("FAIL rd_pause c=%0d got %b want %b", c, pause, c >= 2);
            else passed++;
            if (c == 12) begin
                total++; if (hs_rdata !== 8'hA5) $display("FAIL rd_data got %h want a5", hs_rdata);
                else passed++;
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        int n;
        for (int i = 0; i < 8; i++) begin
            for (int c = 0; c <= 3; c++) begin
                if (c == 0) begin
                    hs_req = 1'b1; hs_we = 1'b0; hs_addr = 16'h6000 + 16'(i);
                end
                #1;
                total++; if (ack !== (c == 3))
                    $display("FAIL burst_ack i=%0d c=%0d got %b want %b", i, c, ack, c == 3);
                else passed++;
                total++; if (pause !== 1'b1) $display("FAIL burst_pause i=%0d got %b want 1", i, pause);
                else passed++;
                if (c == 3) begin
                    total++; if (hs_rdata !== 8'h30 + 8'(i))
                        $display("FAIL burst_data i=%0d got %h want %h", i, hs_rdata, 8'h30 + 8'(i));
                    else passed++;
                end
                tick();
            end
        end
        hs_req = 1'b0;
        n = 0;
        for (int k = 0; k < Hold + 5; k++) begin
            if (!pause) break;
            n++;
            tick();
        end
        total++; if (n !== Hold) $display("FAIL hold_len got %0d want %0d", n, Hold); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL hold_idle got %b want 0", busy); else passed++;
    endtask

    task automatic test_out_of_window;
        paused = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            if (c == 1) begin hs_req = 1'b1; hs_we = 1'b0; hs_addr = 16'h5FFF; end
            if (c == 3) hs_req = 1'b0;
            #1;
            total++; if (ack !== (c == 2)) $display("FAIL oow_ack c=%0d got %b want %b", c, ack, c == 2);
            else passed++;
            total++; if (pause !== 1'b0) $display("FAIL oow_pause c=%0d got %b want 0", c, pause);
            else passed++;
            total++; if (ram_we !== 1'b0) $display("FAIL oow_we c=%0d got %b want 0", c, ram_we);
            else passed++;
            if (c == 2) begin
                total++; if (hs_rdata !== 8'hFF) $display("FAIL oow_data got %h want ff", hs_rdata);
                else passed++;
            end
            tick();
        end
        hs_req = 1'b1; hs_we = 1'b1; hs_addr = 16'h6020; hs_wdata = 8'h3C;
        for (int c = 1; c <= 5; c++) begin
            #1;
            total++; if (ack !== (c == 5)) $display("FAIL oow_wr_ack c=%0d got %b want %b", c, ack, c == 5);
            else passed++;
            tick();
        end
        hs_we = 1'b0; hs_addr = 16'h7000;
        for (int c = 0; c <= 2; c++) begin
            if (c == 2) hs_req = 1'b0;
            #1;
            total++; if (ack !== (c == 1))
                $display("FAIL oowh_ack c=%0d got %b want %b", c, ack, c == 1);
            else passed++;
            total++; if (pause !== 1'b1) $display("FAIL oowh_pause c=%0d got %b want 1", c, pause);
            else passed++;
            if (c == 1) begin
                total++; if (hs_rdata !== 8'hFF) $display("FAIL oowh_data got %h want ff", hs_rdata);
                else passed++;
            end
            tick();
        end
        hs_req = 1'b1; hs_addr = 16'h6020;
        for (int c = 0; c <= 3; c++) begin
            #1;
            total++; if (ack !== (c == 3))
                $display("FAIL oowh_rd_ack c=%0d got %b want %b", c, ack, c == 3);
            else passed++;
            if (c == 3) begin
                total++; if (hs_rdata !== 8'h3C) $display("FAIL oowh_rd_data got %h want 3c", hs_rdata);
                else passed++;
            end
            tick();
        end
        hs_req = 1'b0;
    endtask

    task automatic test_reset_in_settle;
        paused = 1'b0;
        wait_idle();
        paused = 1'b1; hs_req = 1'b1; hs_we = 1'b1; hs_addr = 16'h6030; hs_wdata = 8'h11;
        tick();
        tick();
        #1;
        total++; if (busy !== 1'b1 || pause !== 1'b1)
            $display("FAIL rst_settle_pre got busy=%b pause=%b want 1 1", busy, pause);
        else passed++;
        rstn = 1'b0;
        tick();
        #1;
        total++; if (pause !== 1'b0) $display("FAIL rst_pause got %b want 0", pause); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else passed++;
        total++; if (ram_we !== 1'b0) $display("FAIL rst_we got %b want 0", ram_we); else passed++;
        hs_req = 1'b0;
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            total++; if (ack !== 1'b0) $display("FAIL rst_no_ack c=%0d got %b want 0", c, ack);
            else passed++;
            tick();
        end
        total++; if (mem[12'h030] !== 8'h00) $display("FAIL rst_mem got %h want 00", mem[12'h030]);
        else passed++;
    endtask

    task automatic test_pause_drop;
        wait_idle();
        hs_req = 1'b1; hs_we = 1'b0; hs_addr = 16'h6010;
        for (int c = 1; c <= 11; c++) begin
            paused = !(c >= 3 && c <= 5);
            if (c == 11) hs_req = 1'b0;
            #1;
            total++; if (ack !== (c == 10)) $display("FAIL pd_ack c=%0d got %b want %b", c, ack, c == 10);
            else passed++;
            total++; if (pause !== (c >= 2))
                $display("FAIL pd_pause c=%0d got %b want %b", c, pause, c >= 2);
            else passed++;
            if (c == 8) begin
                total++; if (ram_addr !== 12'h010 || ram_we !== 1'b0)
                    $display("FAIL pd_access got addr=%h we=%b want 010 0", ram_addr, ram_we);
                else passed++;
            end
            if (c == 10) begin
                total++; if (hs_rdata !== 8'hA5) $display("FAIL pd_data got %h want a5", hs_rdata);
                else passed++;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_late_pause_read();
        test_back_to_back();
        test_out_of_window();
        test_reset_in_settle();
        test_pause_drop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

endmodule
